// File: rtl/uart_defs_pkg.sv
// Shared constants for the ram1-bus UART responder: frame geometry and the
// 2-bit state encoding used by both the transmit and receive state machines.
package uart_defs;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 96;   // 11.0592 MHz / 115200 baud
  localparam int BIT_CNT_W        = $clog2(DATA_BITS);

  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// Serial receiver: synchronizes rxd, finds the start edge, samples every bit
// at mid-bit and reports a completed byte or a framing error as 1-cycle pulses.
module uart_rx_core
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 byte_valid,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  logic                 rx_meta, rx_sync, rx_prev;
  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: half-bit start qualification, then one sample per bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UART_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        UART_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= UART_START;
        end
        UART_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // A line already back high at mid start bit was a glitch
            state   <= rx_sync ? UART_IDLE : UART_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_cnt == BIT_LAST) state <= UART_STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // Leave right after the stop sample so a back-to-back start edge is seen
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= UART_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Data shifter, LSB arrives first
  always_ff @(posedge clk) begin
    if (state == UART_DATA && cnt == CNT_LAST) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
  end

  assign rx_data = shreg;

endmodule

// File: rtl/uart_responder.sv
// Device-side UART for the ram1-bus handshake: holding registers, strobe edge
// logic and the 8N1 transmitter; reception is delegated to uart_rx_core.
module uart_responder
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdn,
  input  logic                 wrn,
  input  logic [DATA_BITS-1:0] bus_wdata,
  output logic [DATA_BITS-1:0] bus_rdata,
  output logic                 bus_rdata_oe,
  output logic                 data_ready,
  output logic                 tbre,
  output logic                 tsre,
  output logic                 overrun,
  output logic                 frame_err,
  input  logic                 rxd,
  output logic                 txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  logic                 rdn_q, rdn_prev, wrn_q, wrn_prev;
  logic                 rd_rise, wr_rise, wr_ok, tx_load;
  logic [1:0]           tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_CNT_W-1:0] tx_bit;
  logic [DATA_BITS-1:0] thr, tx_shreg, rhr, rx_data;
  logic                 byte_valid;

  // Register the CPU strobes once and keep one history bit for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_q    <= 1'b1;
      rdn_prev <= 1'b1;
      wrn_q    <= 1'b1;
      wrn_prev <= 1'b1;
    end else begin
      rdn_q    <= rdn;
      rdn_prev <= rdn_q;
      wrn_q    <= wrn;
      wrn_prev <= wrn_q;
    end
  end

  assign rd_rise = rdn_q & ~rdn_prev;
  assign wr_rise = wrn_q & ~wrn_prev;
  // THR moves to the shifter from IDLE, or at the end of STOP for gapless frames
  assign tx_load = ~tbre & ((tx_state == UART_IDLE) ||
                            (tx_state == UART_STOP && tx_cnt == CNT_LAST));
  // A write landing on the transfer cycle is accepted: THR is being emptied
  assign wr_ok   = wr_rise & (tbre | tx_load);

  // Transmit FSM and holding-register status; txd is registered to stay glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      if (wr_ok)        tbre <= 1'b0;
      else if (tx_load) tbre <= 1'b1;
      case (tx_state)
        UART_IDLE: begin
          if (tx_load) begin
            tx_state <= UART_START;
            tx_cnt   <= '0;
            tsre     <= 1'b0;
            txd      <= 1'b0;
          end
        end
        UART_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_state <= UART_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shreg[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_state <= UART_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              txd    <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_load) begin
              tx_state <= UART_START;
              txd      <= 1'b0;
            end else begin
              tx_state <= UART_IDLE;
              tsre     <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Transmit data registers: THR captures the bus, shifter drains LSB first
  always_ff @(posedge clk) begin
    if (wr_ok) thr <= bus_wdata;
    if (tx_load) tx_shreg <= thr;
    else if (tx_state == UART_DATA && tx_cnt == CNT_LAST) tx_shreg <= tx_shreg >> 1;
  end

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Receive holding register: a new byte always beats a read-triggered clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rhr        <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (byte_valid && (!data_ready || rd_rise)) begin
        rhr        <= rx_data;
        data_ready <= 1'b1;
      end else if (rd_rise) begin
        data_ready <= 1'b0;
      end
      if (byte_valid && data_ready && !rd_rise) overrun <= 1'b1;
      else if (rd_rise)                         overrun <= 1'b0;
    end
  end

  assign bus_rdata_oe = ~rdn_q;
  assign bus_rdata    = rdn_q ? '0 : rhr;

endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_responder;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rdn, wrn, rxd;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_oe, data_ready, tbre, tsre, overrun, frame_err, txd;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_count = 0;
  int fe0;

  uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdn          (rdn),
    .wrn          (wrn),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rdata_oe (bus_rdata_oe),
    .data_ready   (data_ready),
    .tbre         (tbre),
    .tsre         (tsre),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .rxd          (rxd),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) fe_count++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(posedge clk); #1 bus_wdata = d; wrn = 1'b0;
    @(posedge clk); #1 wrn = 1'b1;
  endtask

  // Two-cycle read strobe; returns in the window after data_ready has cleared
  task automatic cpu_read(input logic [7:0] exp, input string tag);
    @(posedge clk); #1 rdn = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_oe"}, bus_rdata_oe, 1);
    chk({tag, "_data"}, bus_rdata, exp);
    @(posedge clk); #1 rdn = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 rxd = fr[k];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd = 1'b1;
  endtask

  // Called in the first cycle of the start bit; returns in the last stop-bit cycle
  task automatic expect_frame(input logic [7:0] d, input string tag);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (8) @(negedge clk);
      chk($sformatf("%s_bit%0d", tag, k), txd, fr[k]);
      repeat ((k == 9) ? 7 : 8) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; bus_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    chk("rst_dr", data_ready, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_oe", bus_rdata_oe, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // Single frame 0xA5
    cpu_write(8'hA5);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("a5_tbre_busy", tbre, 0);
    @(negedge clk);
    chk("a5_tbre_free", tbre, 1);
    chk("a5_tsre_busy", tsre, 0);
    expect_frame(8'hA5, "a5");
    chk("a5_tsre_last", tsre, 0);
    @(negedge clk);
    chk("a5_tsre_done", tsre, 1);
    chk("a5_idle_txd", txd, 1);
    repeat (5) @(posedge clk);

    // Back-to-back frames 0x55, 0x0F; a third write while THR is full is dropped
    cpu_write(8'h55);
    @(posedge clk); @(posedge clk); @(negedge clk); @(negedge clk);
    fork
      begin
        expect_frame(8'h55, "b1");
        chk("b2b_tsre_end1", tsre, 0);
        @(negedge clk);
        chk("b2b_tsre_gap", tsre, 0);
        chk("b2b_txd_gap", txd, 0);
        expect_frame(8'h0F, "b2");
        chk("b2b_tsre_end2", tsre, 0);
        @(negedge clk);
        chk("b2b_tsre_done", tsre, 1);
        chk("b2b_tbre_done", tbre, 1);
      end
      begin
        repeat (20) @(posedge clk);
        cpu_write(8'h0F);
        repeat (3) @(posedge clk); #1;
        chk("wr2_accepted", tbre, 0);
        repeat (30) @(posedge clk);
        cpu_write(8'hFF);
        repeat (4) @(posedge clk); #1;
        chk("wr3_dropped_tbre", tbre, 0);
      end
    join
    repeat (40) @(negedge clk);
    chk("no_third_frame", tsre, 1);

    // Receive 0x3C and read it
    chk("rx_dr_before", data_ready, 0);
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    chk("rx3c_dr", data_ready, 1);
    chk("rx3c_ovr", overrun, 0);
    cpu_read(8'h3C, "rd3c");
    chk("rd3c_dr_clr", data_ready, 0);
    chk("rd3c_oe_off", bus_rdata_oe, 0);

    // Overrun: 0x11 then 0x22 with no read in between
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    chk("ovr_dr", data_ready, 1);
    chk("ovr_flag", overrun, 1);
    cpu_read(8'h11, "rd_ovr");
    chk("ovr_clr", overrun, 0);
    chk("ovr_dr_clr", data_ready, 0);

    // Framing error, then a short glitch, then a good byte
    fe0 = fe_count;
    send_byte(8'h7E, 1'b0);
    repeat (4) @(negedge clk);
    chk("fe_pulses", fe_count - fe0, 1);
    chk("fe_dr", data_ready, 0);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (4) @(posedge clk); #1 rxd = 1'b1;
    repeat (40) @(posedge clk); @(negedge clk);
    chk("glitch_dr", data_ready, 0);
    chk("glitch_fe", fe_count - fe0, 1);
    send_byte(8'hC3, 1'b1);
    @(negedge clk);
    chk("post_glitch_dr", data_ready, 1);
    cpu_read(8'hC3, "rd_c3");

    // Reset in the middle of a transmit frame (data bit 4 of 0xA5 is 0)
    cpu_write(8'hA5);
    @(posedge clk); @(posedge clk); @(negedge clk); @(negedge clk);
    repeat (88) @(negedge clk);
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_tsre", tsre, 0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_tbre", tbre, 1);
    chk("midrst_tsre", tsre, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    cpu_write(8'h3C);
    @(posedge clk); @(posedge clk); @(negedge clk); @(negedge clk);
    chk("postrst_tsre", tsre, 0);
    expect_frame(8'h3C, "pr");
    @(negedge clk);
    chk("postrst_done", tsre, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_responder.md
Name: uart_responder

Overview:
- Synthesizable device-side UART that answers the CPU's ram1-bus UART handshake (rdn/wrn strobes; data_ready/tbre/tsre status) and converts bytes to and from an 8N1 serial line.
- Lets the core's serial port run against an on-FPGA UART, or a bench model, in place of the board UART chip.
- The core's ram_uart drives the strobes and the bus. This block is the responder at the other end of that bus.

Parameters:
- CLKS_PER_BIT, 96, clk cycles per serial bit (11.0592 MHz / 115200). Legal values: >= 4, even.
- DATA_BITS, 8, bits per frame payload. Fixed at 8; exposed only for the package constant.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rdn  in  1  read strobe from CPU, active-low, synchronous to clk
- wrn  in  1  write strobe from CPU, active-low, synchronous to clk
- bus_wdata  in  8  low byte of ram1_data during a write
- bus_rdata  out  8  receive holding register value
- bus_rdata_oe  out  1  high while rdn is low; top level drives ram1_data[7:0] from it
- data_ready  out  1  receive holding register full
- tbre  out  1  transmit holding register empty
- tsre  out  1  transmit shift register empty (line idle)
- overrun  out  1  sticky: a received byte was lost
- frame_err  out  1  one-cycle pulse: a stop bit was sampled low
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output, idle high

Behaviour:
- Reset values (async, rst=0): txd=1, tbre=1, tsre=1, data_ready=0, overrun=0, frame_err=0, bus_rdata=0, bus_rdata_oe=0. Both FSMs return to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame. txd goes high immediately.
- Strobe edges: rdn and wrn are registered once. An edge is detected as previous vs current value.
- Write path:
  - Rising edge of wrn seen at cycle N with tbre=1: THR <= bus_wdata, and tbre=0 at N+1.
  - wrn rising while tbre=0: write is dropped, no state change.
- TX FSM (states IDLE, START, DATA, STOP):
  - In IDLE with THR full: shifter <= THR, tbre=1, tsre=0, go to START. This happens one cycle after THR loads.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if THR is full, reload and go to START with no idle gap (tsre stays 0). Otherwise go to IDLE with tsre=1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- RX path:
  - rxd passes through a 2-flop synchronizer before the FSM.
- RX FSM (states IDLE, START, DATA, STOP):
  - IDLE: a falling edge on synced rxd goes to START.
  - START: sample at CLKS_PER_BIT/2. If high, it is a glitch; return to IDLE. If low, go to DATA.
  - DATA: sample each bit at mid-bit, shift in LSB first.
  - STOP: sample at mid-bit. Return to IDLE right after the stop sample, so back-to-back frames are accepted.
- Stop bit high:
  - If data_ready=0: RHR <= byte, data_ready=1.
  - If data_ready=1: RHR keeps its old byte and overrun=1.
- Stop bit low: frame_err pulses for 1 cycle, byte discarded, data_ready unchanged.
- Read path:
  - While registered rdn=0: bus_rdata_oe=1 and bus_rdata=RHR.
  - Rising edge of rdn: data_ready=0 and overrun=0 next cycle.
- Simultaneous events:
  - rdn rising edge in the same cycle an RX byte completes: RHR <= new byte and data_ready stays 1. The new byte wins; no overrun.
  - wrn rising edge in the same cycle as the THR-to-shifter transfer: the transfer sees the old THR. The write is accepted because tbre is updated first in priority.
  - Rule for both: a clear caused by a strobe has lower priority than a set in the same cycle.

Decomposition:
- Package uart_defs holds:
  - DATA_BITS
  - default CLKS_PER_BIT
  - 2-bit state encodings (UART_IDLE, UART_START, UART_DATA, UART_STOP), shared by TX and RX
  - bit-counter width
- Sub-module uart_rx_core: synchronizer, RX FSM and mid-bit sampler. Outputs byte_valid pulse, byte[7:0] and frame_err.
- TX FSM, holding registers and strobe logic stay in uart_responder.

Test Plan (CLKS_PER_BIT=16):
- Write 0xA5 with tbre=1 → tbre: 0 one cycle after the wrn rise, 1 one cycle later. txd: 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1, then 1. tsre returns to 1 after 160 cycles.
- Two writes 0x55 then 0x0F, the second issued once tbre is back to 1 → two frames, 320 cycles total, no idle gap. The second write is accepted; tsre stays 0 throughout.
- Drive serial 0x3C on rxd, then pulse rdn low for 2 cycles → data_ready=1 after the stop sample. bus_rdata=0x3C with oe=1 during rdn. data_ready=0 after the rdn rise.
- Two serial bytes 0x11, 0x22 with no read in between → RHR=0x11 and overrun=1. Both clear on a read.
- Stop bit driven low for byte 0x7E → frame_err pulses once, data_ready stays 0. A 4-cycle rxd low glitch → no byte, FSM back in IDLE.
- rst asserted at the mid-DATA point of a TX frame → txd=1, tbre=1, tsre=1 immediately. A subsequent write transmits a correct frame.
